// File: rtl/exe_muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exe_muldiv_ctrl_pkg
// Shared types and constants for the RV32M multiply/divide sequencer.
//   - muldiv_state_t : FSM state encoding (IDLE / BUSY / DONE)
//   - muldiv_op_t    : func3 encoding of the M-extension operations
//   - FUNC7_MULDIV   : func7 value that marks an R-type instruction as M-type
//   - helpers classifying an op as divide / remainder / signed operand
// Optional feature macro used by the block: MULDIV_FAST_MUL_EN.
// -----------------------------------------------------------------------------
package exe_muldiv_ctrl_pkg;

    localparam int         ARCH_LEN_DEFAULT = 32;
    localparam logic [6:0] FUNC7_MULDIV     = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    // func3[2] separates the divide family from the multiply family.
    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM (not MULHSU).
    function automatic logic op_signed_b(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/exe_muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// exe_muldiv_ctrl_if
// Request/response bundle between the execute stage (master) and the
// multiply/divide sequencer (slave).
//   req_valid_in   : execute stage holds a valid M-type instruction
//   req_func3_in   : M operation (muldiv_op_t encoding)
//   req_op1_in     : rs1 value
//   req_op2_in     : rs2 value
//   kill_in        : flush of the instruction currently in execute
//   stall_out      : hold fetch/decode/execute registers
//   result_valid_out : result_out is valid this cycle (one-cycle pulse)
//   result_out     : M-operation result, held between pulses
//
// Handshake: a request is taken on the first rising edge where the sequencer
// is idle, req_valid_in = 1 and kill_in = 0. From that edge the master keeps
// req_valid_in and the operands stable for as long as stall_out = 1; the
// single cycle with result_valid_out = 1 has stall_out = 0, after which the
// pipeline advances and the master may present the next request. kill_in
// abandons any request in flight and no result pulse follows it.
// -----------------------------------------------------------------------------
interface exe_muldiv_ctrl_if #(
    parameter int ARCH_LEN = 32
) ();
    logic                req_valid_in;
    logic [2:0]          req_func3_in;
    logic [ARCH_LEN-1:0] req_op1_in;
    logic [ARCH_LEN-1:0] req_op2_in;
    logic                kill_in;
    logic                stall_out;
    logic                result_valid_out;
    logic [ARCH_LEN-1:0] result_out;

    modport master (
        output req_valid_in, req_func3_in, req_op1_in, req_op2_in, kill_in,
        input  stall_out, result_valid_out, result_out
    );

    modport slave (
        input  req_valid_in, req_func3_in, req_op1_in, req_op2_in, kill_in,
        output stall_out, result_valid_out, result_out
    );
endinterface

// File: rtl/exe_muldiv_ctrl_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// Iterative unsigned multiply (shift-add) / restoring divide engine.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   start      : load operands (both engines are loaded; only one is stepped)
//   step       : perform one iteration this cycle
//   is_div     : selects which engine a step advances
//   op_a, op_b : unsigned operands (multiplier/dividend, multiplicand/divisor)
//   prod_nxt   : product value after the current step (combinational)
//   quot_nxt   : quotient value after the current step (combinational)
//   rem_nxt    : remainder value after the current step (combinational)
// The *_nxt outputs let the controller capture the final result on the same
// edge that retires the last iteration.
// -----------------------------------------------------------------------------
module muldiv_datapath #(
    parameter int ARCH_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [ARCH_LEN-1:0]   op_a,
    input  logic [ARCH_LEN-1:0]   op_b,
    output logic [2*ARCH_LEN-1:0] prod_nxt,
    output logic [ARCH_LEN-1:0]   quot_nxt,
    output logic [ARCH_LEN-1:0]   rem_nxt
);

    // prod_q holds {accumulator, remaining multiplier bits}.
    logic [2*ARCH_LEN-1:0] prod_q, prod_d;
    // Multiplicand for multiplies, divisor for divides.
    logic [ARCH_LEN-1:0]   opb_q, opb_d;
    // quot_q starts as the dividend and shifts quotient bits in from the right.
    logic [ARCH_LEN-1:0]   quot_q, quot_d;
    logic [ARCH_LEN-1:0]   rem_q, rem_d;

    logic [ARCH_LEN:0]     mul_sum;
    logic [ARCH_LEN:0]     div_shift;
    logic [ARCH_LEN:0]     div_diff;

    // One iteration of each engine.
    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole register right by one.
        mul_sum  = {1'b0, prod_q[2*ARCH_LEN-1:ARCH_LEN]}
                 + (prod_q[0] ? {1'b0, opb_q} : {(ARCH_LEN+1){1'b0}});
        prod_nxt = {mul_sum, prod_q[ARCH_LEN-1:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract,
        // keep the difference only when it did not borrow.
        div_shift = {rem_q, quot_q[ARCH_LEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (!div_diff[ARCH_LEN]) begin
            rem_nxt  = div_diff[ARCH_LEN-1:0];
            quot_nxt = {quot_q[ARCH_LEN-2:0], 1'b1};
        end else begin
            rem_nxt  = div_shift[ARCH_LEN-1:0];
            quot_nxt = {quot_q[ARCH_LEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_d = prod_q;
        opb_d  = opb_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        if (start) begin
            prod_d = {{ARCH_LEN{1'b0}}, op_a};
            opb_d  = op_b;
            quot_d = op_a;
            rem_d  = '0;
        end else if (step) begin
            if (is_div) begin
                quot_d = quot_nxt;
                rem_d  = rem_nxt;
            end else begin
                prod_d = prod_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= '0;
            opb_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            prod_q <= prod_d;
            opb_q  <= opb_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// exe_muldiv_ctrl
// Multi-cycle RV32M multiply/divide sequencer for the execute stage. Accepts a
// request, stalls the front of the pipeline while muldiv_datapath iterates,
// and returns the result as a one-cycle pulse. Divide-by-zero and signed
// overflow complete in one cycle; kill_in abandons the operation.
// Ports:
//   clk           : clock
//   rst           : synchronous active-low reset
//   md            : exe_muldiv_ctrl_if slave (request, kill, stall, result)
//   dbg_state_out : current FSM state
// Macro: MULDIV_FAST_MUL_EN -- when defined, multiplies complete in one cycle
// using a single-cycle multiplier; divides are unaffected.
// -----------------------------------------------------------------------------
module exe_muldiv_ctrl
    import exe_muldiv_ctrl_pkg::*;
#(
    parameter int ARCH_LEN = ARCH_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    exe_muldiv_ctrl_if.slave     md,
    output muldiv_state_t        dbg_state_out
);

    localparam logic [5:0]          LAST_CNT = 6'(ARCH_LEN - 1);
    localparam logic [ARCH_LEN-1:0] MIN_NEG  = {1'b1, {(ARCH_LEN-1){1'b0}}};

    muldiv_state_t       state_q, state_d;
    logic [5:0]          count_q, count_d;
    muldiv_op_t          func3_q, func3_d;
    // Sign of product/quotient, and sign of remainder (follows the dividend).
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [ARCH_LEN-1:0] result_q, result_d;
    logic                result_valid_q, result_valid_d;

    // Request decode on the live inputs (used in the accepting cycle only).
    muldiv_op_t          func3_in;
    logic                in_is_div, in_is_rem;
    logic                a_neg_in, b_neg_in;
    logic [ARCH_LEN-1:0] a_abs_in, b_abs_in;
    logic                div_by_zero, div_ovf;
    logic                accept;

    // Datapath hookup.
    logic                  dp_start, dp_step, dp_is_div;
    logic [2*ARCH_LEN-1:0] dp_prod_nxt;
    logic [ARCH_LEN-1:0]   dp_quot_nxt, dp_rem_nxt;
    logic [2*ARCH_LEN-1:0] prod_fix;
    logic [ARCH_LEN-1:0]   quot_fix, rem_fix;
    logic                  stall;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [ARCH_LEN:0]     fast_a, fast_b;
    logic signed [2*ARCH_LEN+1:0] fast_full;
    logic [2*ARCH_LEN-1:0]        fast_prod;
`endif

    function automatic logic [ARCH_LEN-1:0] select_result(
        input muldiv_op_t            op,
        input logic [2*ARCH_LEN-1:0] prod,
        input logic [ARCH_LEN-1:0]   quot,
        input logic [ARCH_LEN-1:0]   rem
    );
        case (op)
            OP_MUL:                       return prod[ARCH_LEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*ARCH_LEN-1:ARCH_LEN];
            OP_DIV, OP_DIVU:              return quot;
            default:                      return rem;
        endcase
    endfunction

    always_comb begin
        func3_in    = muldiv_op_t'(md.req_func3_in);
        in_is_div   = op_is_div(func3_in);
        in_is_rem   = op_is_rem(func3_in);
        a_neg_in    = op_signed_a(func3_in) & md.req_op1_in[ARCH_LEN-1];
        b_neg_in    = op_signed_b(func3_in) & md.req_op2_in[ARCH_LEN-1];
        a_abs_in    = a_neg_in ? -md.req_op1_in : md.req_op1_in;
        b_abs_in    = b_neg_in ? -md.req_op2_in : md.req_op2_in;
        div_by_zero = in_is_div & (md.req_op2_in == '0);
        // Only the signed divide family can overflow (MIN / -1).
        div_ovf     = in_is_div & op_signed_b(func3_in)
                    & (md.req_op1_in == MIN_NEG) & (md.req_op2_in == '1);
        accept      = (state_q == MD_IDLE) & md.req_valid_in & ~md.kill_in;
    end

`ifdef MULDIV_FAST_MUL_EN
    // 33-bit operands: sign-extended when signed, zero-extended otherwise.
    always_comb begin
        fast_a    = {op_signed_a(func3_in) & md.req_op1_in[ARCH_LEN-1], md.req_op1_in};
        fast_b    = {op_signed_b(func3_in) & md.req_op2_in[ARCH_LEN-1], md.req_op2_in};
        fast_full = fast_a * fast_b;
        fast_prod = fast_full[2*ARCH_LEN-1:0];
    end
`endif

    // Sign fix-up applied to the values produced by the final iteration.
    always_comb begin
        prod_fix = neg_res_q ? -dp_prod_nxt : dp_prod_nxt;
        quot_fix = neg_res_q ? -dp_quot_nxt : dp_quot_nxt;
        rem_fix  = neg_rem_q ? -dp_rem_nxt  : dp_rem_nxt;
    end

    // ---------------------------------------------------------------- FSM
    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= MD_IDLE;
            count_q        <= '0;
            func3_q        <= OP_MUL;
            neg_res_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            func3_q        <= func3_d;
            neg_res_q      <= neg_res_d;
            neg_rem_q      <= neg_rem_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Next-state logic. Kill overrides both acceptance and completion.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        func3_d   = func3_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (md.kill_in) begin
            state_d = MD_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md.req_valid_in) begin
                        func3_d   = func3_in;
                        neg_res_d = a_neg_in ^ b_neg_in;
                        neg_rem_d = a_neg_in;
                        count_d   = '0;
                        if (div_by_zero || div_ovf) begin
                            state_d = MD_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!in_is_div) begin
                            state_d = MD_DONE;
`endif
                        end else begin
                            state_d = MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (count_q == LAST_CNT) begin
                        state_d = MD_DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: begin
                    state_d = MD_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Output logic: stall, datapath controls, and the result register inputs.
    always_comb begin
        stall          = rst & md.req_valid_in & (state_q != MD_DONE) & ~md.kill_in;
        dp_start       = accept;
        dp_step        = (state_q == MD_BUSY) & ~md.kill_in;
        dp_is_div      = op_is_div(func3_q);
        result_valid_d = (state_d == MD_DONE);
        result_d       = result_q;
        if (accept) begin
            if (div_by_zero) begin
                result_d = in_is_rem ? md.req_op1_in : '1;
            end else if (div_ovf) begin
                result_d = in_is_rem ? '0 : MIN_NEG;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!in_is_div) begin
                result_d = select_result(func3_in, fast_prod, '0, '0);
`endif
            end
        end else if (dp_step && (count_q == LAST_CNT)) begin
            result_d = select_result(func3_q, prod_fix, quot_fix, rem_fix);
        end
    end

    muldiv_datapath #(
        .ARCH_LEN (ARCH_LEN)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .start    (dp_start),
        .step     (dp_step),
        .is_div   (dp_is_div),
        .op_a     (a_abs_in),
        .op_b     (b_abs_in),
        .prod_nxt (dp_prod_nxt),
        .quot_nxt (dp_quot_nxt),
        .rem_nxt  (dp_rem_nxt)
    );

    assign md.stall_out        = stall;
    assign md.result_valid_out = result_valid_q;
    assign md.result_out       = result_q;
    assign dbg_state_out       = state_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exe_muldiv_ctrl
// Directed self-checking bench for exe_muldiv_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge or 1 unit
// after the rising edge. Cycle 0 is the cycle in which a request is presented
// to an idle sequencer; the result pulse is expected in cycle 33 for iterative
// ops and cycle 1 for special-case divides (and fast multiplies).
// -----------------------------------------------------------------------------
module tb_exe_muldiv_ctrl;
    import exe_muldiv_ctrl_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic          clk = 1'b0;
    logic          rst;
    muldiv_state_t dbg_state;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    exe_muldiv_ctrl_if #(.ARCH_LEN(32)) md_if ();

    exe_muldiv_ctrl #(.ARCH_LEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .md            (md_if),
        .dbg_state_out (dbg_state)
    );

    // ------------------------------------------------------------ drivers
    task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        md_if.req_valid_in = 1'b1;
        md_if.req_func3_in = f;
        md_if.req_op1_in   = a;
        md_if.req_op2_in   = b;
    endtask

    task automatic drive_idle();
        md_if.req_valid_in = 1'b0;
        md_if.req_func3_in = 3'b000;
        md_if.req_op1_in   = '0;
        md_if.req_op2_in   = '0;
        md_if.kill_in      = 1'b0;
    endtask

    // Called during cycle 0 (request already presented). Follows the op to its
    // result pulse, checking latency, value and the stall profile, then drops
    // the request in the result cycle.
    task automatic wait_result(input string name, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic        stall_ok;
        logic [31:0] got;
        lat      = -1;
        stall_ok = 1'b1;
        got      = '0;
        @(negedge clk);
        if (md_if.stall_out !== 1'b1 || md_if.result_valid_out !== 1'b0) stall_ok = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (md_if.result_valid_out === 1'b1) begin
                lat = n;
                got = md_if.result_out;
                if (md_if.stall_out !== 1'b0) stall_ok = 1'b0;
            end else if (md_if.stall_out !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        md_if.req_valid_in = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (-1 = no pulse) expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (got !== exp_res) begin
            errors++;
            $display("FAIL %s result: got 0x%08h expected 0x%08h", name, got, exp_res);
        end
        checks++;
        if (stall_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s stall profile: got irregular stall/valid, expected stall high until result cycle", name);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        @(posedge clk);
        #1;
        present(f, a, b);
        wait_result(name, exp_res, exp_lat);
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        present(3'b101, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== MD_IDLE) begin
            errors++;
            $display("FAIL reset state: got %0d expected %0d", dbg_state, MD_IDLE);
        end
        checks++;
        if (md_if.result_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset result_valid: got %b expected 0", md_if.result_valid_out);
        end
        checks++;
        if (md_if.result_out !== 32'h0) begin
            errors++;
            $display("FAIL reset result: got 0x%08h expected 0x00000000", md_if.result_out);
        end
        checks++;
        if (md_if.stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset stall: got %b expected 0", md_if.stall_out);
        end
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b1;
    endtask

    task automatic test_mul();
        run_op("mul_7_x_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    endtask

    task automatic test_mulh_variants();
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_m1_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
    endtask

    task automatic test_div_iter();
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT);
    endtask

    task automatic test_div_special();
        run_op("div_by_zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_by_zero", 3'b110, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    endtask

    task automatic test_kill();
        logic saw_pulse;
        saw_pulse = 1'b0;
        @(posedge clk);
        #1;
        present(3'b101, 32'd100, 32'd7);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (md_if.result_valid_out !== 1'b0) saw_pulse = 1'b1;
        end
        md_if.kill_in = 1'b1;
        @(negedge clk);
        checks++;
        if (md_if.stall_out !== 1'b0) begin
            errors++;
            $display("FAIL kill stall: got %b expected 0", md_if.stall_out);
        end
        @(posedge clk);
        #1;
        md_if.kill_in = 1'b0;
        if (md_if.result_valid_out !== 1'b0) saw_pulse = 1'b1;
        checks++;
        if (dbg_state !== MD_IDLE) begin
            errors++;
            $display("FAIL kill state: got %0d expected %0d", dbg_state, MD_IDLE);
        end
        checks++;
        if (saw_pulse !== 1'b0) begin
            errors++;
            $display("FAIL kill no_result: got a result pulse, expected none");
        end
        present(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_result("mul_after_kill", 32'hFFFF_FFEB, MUL_LAT);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        @(posedge clk);
        #1;
        checks++;
        if (md_if.result_out !== 32'd14 || md_if.result_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b hold: got valid=%b result=0x%08h expected valid=0 result=0x0000000e",
                     md_if.result_valid_out, md_if.result_out);
        end
        present(3'b111, 32'd100, 32'd7);
        wait_result("b2b_remu", 32'd2, DIV_LAT);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (md_if.result_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b single_pulse: got valid=%b expected 0", md_if.result_valid_out);
        end
    endtask

    task automatic test_reset_busy();
        @(posedge clk);
        #1;
        present(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (md_if.stall_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy stall: got %b expected 0", md_if.stall_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== MD_IDLE || md_if.result_valid_out !== 1'b0 || md_if.result_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_busy outputs: got state=%0d valid=%b result=0x%08h expected state=0 valid=0 result=0x00000000",
                     dbg_state, md_if.result_valid_out, md_if.result_out);
        end
        drive_idle();
        rst = 1'b1;
        test_back_to_back();
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        test_reset();
        test_mul();
        test_mulh_variants();
        test_div_iter();
        test_div_special();
        test_kill();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
